mem_cache_controller: RTL and testbench

//   Next-generation memory front end between the RV32E core and mem_external (SPI flash/PSRAM).

---
 rtl/mem_pkg.sv | 39 +++
 rtl/mem_cache_controller_if.sv | 24 ++
 rtl/mem_cache_array.sv | 53 +++++
 rtl/mem_cache_controller.sv | 200 ++++++++++++++++++++
 tb/tb_mem_cache_controller.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the cached memory front end.
package mem_pkg;

  localparam logic [2:0]  NUM_BYTES_WORD = 3'd4;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Core request latched for the duration of a transaction
  typedef struct packed {
    logic              is_data;
    logic              is_write;
    logic [2:0]        num_bytes;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

  function automatic int unsigned index_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned lines);
    return addr_w - $clog2(lines) - 2;
  endfunction

  function automatic logic is_cacheable(input logic       is_data,
                                        input logic       is_write,
                                        input logic [2:0] num_bytes,
                                        input logic [1:0] addr_lo,
                                        input logic       cache_data);
    return !is_write && (num_bytes == NUM_BYTES_WORD) && (addr_lo == 2'b00) &&
           (!is_data || cache_data);
  endfunction

endpackage

// File: rtl/mem_cache_controller_if.sv
// Core-side level handshake between the RV32E core and the memory front end.
interface mem_cache_controller_if;

  logic        start_request;
  logic        is_data_fetch;
  logic        is_write;
  logic [2:0]  num_bytes;
  logic [31:0] target_address;
  logic [31:0] write_value;
  logic [31:0] fetched_instruction;
  logic [31:0] fetched_data;
  logic        request_done;

  modport master (
    output start_request, is_data_fetch, is_write, num_bytes, target_address, write_value,
    input  fetched_instruction, fetched_data, request_done
  );

  modport slave (
    input  start_request, is_data_fetch, is_write, num_bytes, target_address, write_value,
    output fetched_instruction, fetched_data, request_done
  );

endinterface

// File: rtl/mem_cache_array.sv
// Direct-mapped word store: combinational lookup, synchronous write/invalidate, flush.
module mem_cache_array #(
  parameter int unsigned LINES = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned TAG_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             hit_c,
  output logic [31:0]      rd_data_c,
  input  logic             wr_en_i,
  input  logic             inval_en_i,
  input  logic [31:0]      wr_data_i
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // A flush in the same cycle makes the lookup see an empty cache
  assign hit_c     = !flush_i && valid_q[idx_i] && (tag_q[idx_i] == tag_i);
  assign rd_data_c = data_q[idx_i];

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (wr_en_i) begin
      valid_d[idx_i] = 1'b1;
    end else if (inval_en_i) begin
      valid_d[idx_i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/mem_cache_controller.sv
// Memory front end with a direct-mapped write-through word cache in front of mem_external.
module mem_cache_controller
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned LINES      = 8,
  parameter bit          CACHE_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_cache_controller_if.slave  core,
  input  logic                   flush,
  output logic                   mem_start_request,
  output logic                   mem_is_write,
  output logic [2:0]             mem_num_bytes,
  output logic [31:0]            mem_address,
  output logic [31:0]            mem_write_value,
  input  logic [31:0]            mem_read_data,
  input  logic                   mem_request_done,
  output logic [CNT_W-1:0]       hit_count,
  output logic [CNT_W-1:0]       miss_count
);

  localparam int unsigned IDX_W = index_width(LINES);
  localparam int unsigned TAG_W = tag_width(ADDR_W, LINES);

  state_e            state_q, state_d;
  req_t              req_q, req_d, core_req;
  logic              cacheable_q, cacheable_d;
  logic              aborted_q, aborted_d;
  logic              flushed_q, flushed_d;
  logic              done_q, done_d;
  logic              mem_start_q, mem_start_d;
  logic [31:0]       finstr_q, finstr_d;
  logic [31:0]       fdata_q, fdata_d;
  logic [CNT_W-1:0]  hit_q, hit_d, miss_q, miss_d;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit_c;
  logic [31:0]       lk_data_c;
  logic              wr_en, inval_en;
  logic [31:0]       wr_data;
  logic              accept, core_cacheable, finish_to_done;

  always_comb begin
    core_req           = '0;
    core_req.is_data   = core.is_data_fetch;
    core_req.is_write  = core.is_write;
    core_req.num_bytes = core.num_bytes;
    core_req.addr      = core.target_address;
    core_req.wdata     = core.write_value;
  end

  assign core_cacheable = is_cacheable(core.is_data_fetch, core.is_write, core.num_bytes,
                                       core.target_address[1:0], CACHE_DATA);
  assign accept         = core.start_request && !done_q && !mem_request_done;
  assign finish_to_done = !aborted_q && core.start_request;

  // Lookup uses the live core address when idle, the latched one while the SPI transfer runs
  assign lk_idx = (state_q == ST_IDLE) ? core.target_address[IDX_W+1:2]      : req_q.addr[IDX_W+1:2];
  assign lk_tag = (state_q == ST_IDLE) ? core.target_address[ADDR_W-1:IDX_W+2] : req_q.addr[ADDR_W-1:IDX_W+2];

  mem_cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .idx_i      (lk_idx),
    .tag_i      (lk_tag),
    .hit_c      (lk_hit_c),
    .rd_data_c  (lk_data_c),
    .wr_en_i    (wr_en),
    .inval_en_i (inval_en),
    .wr_data_i  (wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = (core_cacheable && lk_hit_c) ? ST_DONE : ST_MEM;
      ST_MEM:  if (mem_request_done) state_d = finish_to_done ? ST_DONE : ST_IDLE;
      ST_DONE: if (!core.start_request) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d       = req_q;
    cacheable_d = cacheable_q;
    aborted_d   = aborted_q;
    flushed_d   = flushed_q;
    done_d      = done_q;
    mem_start_d = mem_start_q;
    finstr_d    = finstr_q;
    fdata_d     = fdata_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    wr_en       = 1'b0;
    inval_en    = 1'b0;
    wr_data     = req_q.wdata;
    unique case (state_q)
      ST_IDLE: begin
        aborted_d = 1'b0;
        flushed_d = 1'b0;
        if (accept) begin
          req_d       = core_req;
          cacheable_d = core_cacheable;
          if (core_cacheable && lk_hit_c) begin
            done_d   = 1'b1;
            finstr_d = core_req.is_data ? 32'd0 : lk_data_c;
            fdata_d  = core_req.is_data ? lk_data_c : 32'd0;
            hit_d    = (&hit_q) ? hit_q : hit_q + CNT_W'(1);
          end else begin
            mem_start_d = 1'b1;
            if (core_cacheable) miss_d = (&miss_q) ? miss_q : miss_q + CNT_W'(1);
          end
        end
      end
      ST_MEM: begin
        if (!core.start_request) aborted_d = 1'b1;
        if (flush) flushed_d = 1'b1;
        if (mem_request_done) begin
          mem_start_d = 1'b0;
          // A fill fetched across a flush may be stale, so it is dropped
          if (cacheable_q) begin
            wr_en   = !flushed_q;
            wr_data = mem_read_data;
          end else if (req_q.is_write && lk_hit_c) begin
            if ((req_q.num_bytes == NUM_BYTES_WORD) && (req_q.addr[1:0] == 2'b00)) wr_en = 1'b1;
            else inval_en = 1'b1;
          end
          if (finish_to_done) begin
            done_d   = 1'b1;
            finstr_d = req_q.is_data ? 32'd0 : mem_read_data;
            fdata_d  = req_q.is_data ? mem_read_data : 32'd0;
          end
        end
      end
      ST_DONE: begin
        if (!core.start_request) begin
          done_d   = 1'b0;
          finstr_d = 32'd0;
          fdata_d  = 32'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      cacheable_q <= 1'b0;
      aborted_q   <= 1'b0;
      flushed_q   <= 1'b0;
      done_q      <= 1'b0;
      mem_start_q <= 1'b0;
      finstr_q    <= '0;
      fdata_q     <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      req_q       <= req_d;
      cacheable_q <= cacheable_d;
      aborted_q   <= aborted_d;
      flushed_q   <= flushed_d;
      done_q      <= done_d;
      mem_start_q <= mem_start_d;
      finstr_q    <= finstr_d;
      fdata_q     <= fdata_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign core.request_done        = done_q;
  assign core.fetched_instruction = finstr_q;
  assign core.fetched_data        = fdata_q;
  assign mem_start_request        = mem_start_q;
  assign mem_is_write             = req_q.is_write;
  assign mem_num_bytes            = req_q.num_bytes;
  assign mem_address              = req_q.addr;
  assign mem_write_value          = req_q.wdata;
  assign hit_count                = hit_q;
  assign miss_count               = miss_q;

endmodule

// File: tb/tb_mem_cache_controller.sv
// Self-checking bench: directed vector table, corner sequences, random traffic against a cache model.
module tb_mem_cache_controller;

  localparam int LINES   = 8;
  localparam int CNT_MAX = 15;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        mem_start_request, mem_is_write;
  logic [2:0]  mem_num_bytes;
  logic [31:0] mem_address, mem_write_value;
  logic [31:0] mem_read_data    = '0;
  logic        mem_request_done = 1'b0;
  logic [3:0]  hit_count, miss_count;

  mem_cache_controller_if bus ();

  mem_cache_controller #(
    .ADDR_W (24), .LINES (LINES), .CACHE_DATA (1'b1), .CNT_W (4)
  ) dut (
    .clk (clk), .rst_n (rst_n), .core (bus), .flush (flush),
    .mem_start_request (mem_start_request), .mem_is_write (mem_is_write),
    .mem_num_bytes (mem_num_bytes), .mem_address (mem_address),
    .mem_write_value (mem_write_value), .mem_read_data (mem_read_data),
    .mem_request_done (mem_request_done), .hit_count (hit_count), .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [2:0] nb, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (b < int'(nb) && int'(off) + b < 4) r[(int'(off) + b) * 8 +: 8] = wd[b * 8 +: 8];
    return r;
  endfunction

  // External memory stand-in: fixed latency, full aligned word returned on reads
  logic [31:0] mem_arr [256];
  int          mem_lat      = 4;
  int          lat_cnt      = 0;
  int          mem_done_cnt = 0;
  logic        last_we      = 1'b0;
  logic [2:0]  last_nb      = '0;
  logic [31:0] last_addr    = '0;
  logic [31:0] last_wdata   = '0;

  always @(posedge clk) begin
    if (!mem_start_request) begin
      mem_request_done <= 1'b0;
      lat_cnt          <= 0;
    end else if (!mem_request_done) begin
      if (lat_cnt >= mem_lat) begin
        mem_request_done <= 1'b1;
        mem_read_data    <= mem_arr[mem_address[9:2]];
        mem_done_cnt     <= mem_done_cnt + 1;
        last_we          <= mem_is_write;
        last_nb          <= mem_num_bytes;
        last_addr        <= mem_address;
        last_wdata       <= mem_write_value;
        if (mem_is_write)
          mem_arr[mem_address[9:2]] <= merge(mem_arr[mem_address[9:2]], mem_write_value,
                                             mem_num_bytes, mem_address[1:0]);
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] r_fi, r_fd;
  int          r_cyc, r_nmem;

  task automatic drive(input logic d, input logic w, input logic [2:0] nb,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.is_data_fetch  = d;
    bus.is_write       = w;
    bus.num_bytes      = nb;
    bus.target_address = a;
    bus.write_value    = wd;
    bus.start_request  = 1'b1;
  endtask

  // sel: 0 mem_start_request, 1 mem_request_done, 2 request_done
  function automatic logic sig(input int sel);
    case (sel)
      0:       return mem_start_request;
      1:       return mem_request_done;
      default: return bus.request_done;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input string name);
    int n;
    n = 0;
    while (sig(sel) !== val && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(sig(sel)), 64'(val));
  endtask

  task automatic release_req();
    @(negedge clk);
    bus.start_request = 1'b0;
    wait_sig(2, 1'b0, "done_release");
  endtask

  task automatic do_req(input logic d, input logic w, input logic [2:0] nb,
                        input logic [31:0] a, input logic [31:0] wd, input logic fl);
    int c0;
    c0 = mem_done_cnt;
    @(negedge clk);
    drive(d, w, nb, a, wd);
    flush = fl;
    r_cyc = 0;
    do begin
      @(posedge clk); #1;
      flush = 1'b0;
      r_cyc++;
    end while (!bus.request_done && r_cyc < 300);
    chk("req_timeout", 64'(bus.request_done), 64'd1);
    r_fi   = bus.fetched_instruction;
    r_fd   = bus.fetched_data;
    r_nmem = mem_done_cnt - c0;
    release_req();
  endtask

  task automatic chk_read(input string name, input logic d, input logic [31:0] exp);
    chk({name, "_instr"}, 64'(r_fi), 64'(d ? 32'd0 : exp));
    chk({name, "_data"},  64'(r_fd), 64'(d ? exp : 32'd0));
  endtask

  typedef struct {
    logic        d;
    logic        w;
    logic [2:0]  nb;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_hit;
    int          exp_nmem;
    logic [31:0] exp_rd;
    int          exp_h;
    int          exp_m;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] ref_mem [256];
  logic        m_valid [LINES];
  int          m_tag   [LINES];
  int          eh, em;

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    mem_arr[8'h40] = 32'hDEADBEEF;
    mem_arr[8'h48] = 32'hCAFEF00D;
    mem_arr[8'h80] = 32'hAAAA5555;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_request = 1'b0; bus.is_data_fetch = 1'b0; bus.is_write = 1'b0;
    bus.num_bytes = 3'd0; bus.target_address = '0; bus.write_value = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_request_done", 64'(bus.request_done), 64'd0);
    chk("rst_mem_start",    64'(mem_start_request), 64'd0);
    chk("rst_mem_address",  64'(mem_address), 64'd0);
    chk("rst_counts",       64'({hit_count, miss_count}), 64'd0);
    chk("rst_fetched",      64'({bus.fetched_instruction, bus.fetched_data}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0]  = '{1'b0, 1'b0, 3'd4, 32'h100, 32'h0,        1'b0, 1, 32'hDEADBEEF, 0, 1};
    vecs[1]  = '{1'b0, 1'b0, 3'd4, 32'h100, 32'h0,        1'b1, 0, 32'hDEADBEEF, 1, 1};
    vecs[2]  = '{1'b0, 1'b0, 3'd4, 32'h120, 32'h0,        1'b0, 1, 32'hCAFEF00D, 1, 2};
    vecs[3]  = '{1'b0, 1'b0, 3'd4, 32'h100, 32'h0,        1'b0, 1, 32'hDEADBEEF, 1, 3};
    vecs[4]  = '{1'b1, 1'b0, 3'd4, 32'h200, 32'h0,        1'b0, 1, 32'hAAAA5555, 1, 4};
    vecs[5]  = '{1'b1, 1'b1, 3'd4, 32'h200, 32'h12345678, 1'b0, 1, 32'h0,        1, 4};
    vecs[6]  = '{1'b1, 1'b0, 3'd4, 32'h200, 32'h0,        1'b1, 0, 32'h12345678, 2, 4};
    vecs[7]  = '{1'b1, 1'b1, 3'd1, 32'h200, 32'h00000099, 1'b0, 1, 32'h0,        2, 4};
    vecs[8]  = '{1'b1, 1'b0, 3'd4, 32'h200, 32'h0,        1'b0, 1, 32'h12345699, 2, 5};
    vecs[9]  = '{1'b1, 1'b0, 3'd4, 32'h200, 32'h0,        1'b1, 0, 32'h12345699, 3, 5};
    vecs[10] = '{1'b1, 1'b0, 3'd2, 32'h200, 32'h0,        1'b0, 1, 32'h12345699, 3, 5};

    mem_lat = 40;
    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].d, vecs[i].w, vecs[i].nb, vecs[i].addr, vecs[i].wd, 1'b0);
      chk($sformatf("vec%0d_hit", i),  64'(r_cyc == 1), 64'(vecs[i].exp_hit));
      chk($sformatf("vec%0d_nmem", i), 64'(r_nmem), 64'(vecs[i].exp_nmem));
      if (!vecs[i].w) begin
        chk_read($sformatf("vec%0d", i), vecs[i].d, vecs[i].exp_rd);
      end else begin
        chk($sformatf("vec%0d_mem_wr", i), 64'({last_we, last_nb, last_addr, last_wdata}),
            64'({1'b1, vecs[i].nb, vecs[i].addr, vecs[i].wd}));
      end
      chk($sformatf("vec%0d_hits", i),   64'(hit_count),  64'(vecs[i].exp_h));
      chk($sformatf("vec%0d_misses", i), 64'(miss_count), 64'(vecs[i].exp_m));
    end
    eh = 3; em = 5;

    // Flush in the same cycle as the request: lookup sees an empty cache
    mem_lat = 8;
    do_req(1'b0, 1'b0, 3'd4, 32'h104, 32'h0, 1'b0);
    em++;
    do_req(1'b0, 1'b0, 3'd4, 32'h104, 32'h0, 1'b1);
    em++;
    chk("idle_flush_hit", 64'(r_cyc == 1), 64'd0);
    chk("idle_flush_nmem", 64'(r_nmem), 64'd1);
    chk("idle_flush_misses", 64'(miss_count), 64'(em));

    // Flush pulse in the middle of a miss
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd4, 32'h300, 32'h0);
    wait_sig(0, 1'b1, "midflush_mem_start");
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_sig(2, 1'b1, "midflush_done");
    chk("midflush_data", 64'(bus.fetched_instruction), 64'(mem_arr[8'hC0]));
    release_req();
    em++;
    do_req(1'b0, 1'b0, 3'd4, 32'h300, 32'h0, 1'b0);
    em++;
    chk("midflush_rehit", 64'(r_cyc == 1), 64'd0);
    chk("midflush_nmem", 64'(r_nmem), 64'd1);

    // Flush on exactly the completion edge: the fill is dropped
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd4, 32'h340, 32'h0);
    wait_sig(1, 1'b1, "edgeflush_mem_done");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_sig(2, 1'b1, "edgeflush_done");
    chk("edgeflush_data", 64'(bus.fetched_instruction), 64'(mem_arr[8'hD0]));
    release_req();
    em++;
    do_req(1'b0, 1'b0, 3'd4, 32'h340, 32'h0, 1'b0);
    em++;
    chk("edgeflush_rehit", 64'(r_cyc == 1), 64'd0);
    chk("edgeflush_misses", 64'(miss_count), 64'(em > CNT_MAX ? CNT_MAX : em));

    // Core abandons a miss: transfer completes, no request_done, line still filled
    begin
      logic any_done;
      @(negedge clk);
      drive(1'b0, 1'b0, 3'd4, 32'h144, 32'h0);
      wait_sig(0, 1'b1, "abort_mem_start");
      @(negedge clk);
      bus.start_request = 1'b0;
      any_done = 1'b0;
      for (int n = 0; n < 60; n++) begin
        @(posedge clk); #1;
        any_done |= bus.request_done;
      end
      chk("abort_mem_idle", 64'(mem_start_request), 64'd0);
      chk("abort_no_done", 64'(any_done), 64'd0);
      chk("abort_fetched", 64'(bus.fetched_instruction), 64'd0);
      do_req(1'b0, 1'b0, 3'd4, 32'h144, 32'h0, 1'b0);
      chk("abort_filled_hit", 64'(r_cyc == 1), 64'd1);
      chk_read("abort_filled", 1'b0, mem_arr[8'h51]);
    end

    // Reset during a miss
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd4, 32'h184, 32'h0);
    wait_sig(0, 1'b1, "rstmid_mem_start");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_mem_start", 64'(mem_start_request), 64'd0);
    chk("rstmid_done", 64'(bus.request_done), 64'd0);
    chk("rstmid_counts", 64'({hit_count, miss_count}), 64'd0);
    bus.start_request = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 1'b0, 3'd4, 32'h144, 32'h0, 1'b0);
    chk("rstmid_prior_hit_misses", 64'(r_cyc == 1), 64'd0);
    chk("rstmid_miss_count", 64'(miss_count), 64'd1);

    // Hit counter saturation
    for (int n = 0; n < 20; n++) do_req(1'b0, 1'b0, 3'd4, 32'h144, 32'h0, 1'b0);
    chk("sat_last_hit", 64'(r_cyc == 1), 64'd1);
    chk("sat_hit_count", 64'(hit_count), 64'(CNT_MAX));
    chk("sat_miss_count", 64'(miss_count), 64'd1);

    // Random traffic against a transaction-level cache model
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_arr[i];
    for (int l = 0; l < LINES; l++) begin m_valid[l] = 1'b0; m_tag[l] = 0; end
    eh = 0; em = 0;
    for (int t = 0; t < 250; t++) begin
      int          op, idx, tg;
      logic        d, w, fl, cach, e_hit;
      logic [2:0]  nb;
      logic [31:0] a, wd;
      op = $urandom_range(0, 9);
      a  = 32'($urandom_range(0, 31)) << 2;
      d  = 1'($urandom_range(0, 1));
      wd = $urandom;
      fl = ($urandom_range(0, 15) == 0);
      w  = 1'b0;
      nb = 3'd4;
      if (op == 6) begin
        nb = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd2;
        a  = a + ((nb == 3'd1) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 1) * 2));
      end else if (op >= 7) begin
        w  = 1'b1;
        nb = (op == 7) ? 3'd4 : (op == 8) ? 3'd1 : 3'd2;
        if (op == 8) a = a + 32'($urandom_range(0, 3));
        if (op == 9) a = a + 32'($urandom_range(0, 1) * 2);
      end
      mem_lat = $urandom_range(1, 6);

      idx = int'(a[4:2]);
      tg  = int'(a[23:5]);
      if (fl) for (int l = 0; l < LINES; l++) m_valid[l] = 1'b0;
      cach  = !w && nb == 3'd4 && a[1:0] == 2'b00;
      e_hit = cach && m_valid[idx] && m_tag[idx] == tg;
      if (cach && e_hit) begin
        if (eh < CNT_MAX) eh++;
      end else if (cach) begin
        if (em < CNT_MAX) em++;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
      end else if (w) begin
        ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], wd, nb, a[1:0]);
        if (m_valid[idx] && m_tag[idx] == tg && !(nb == 3'd4 && a[1:0] == 2'b00))
          m_valid[idx] = 1'b0;
      end

      do_req(d, w, nb, a, wd, fl);
      chk($sformatf("rnd%0d_hit", t), 64'(r_cyc == 1), 64'(e_hit));
      chk($sformatf("rnd%0d_nmem", t), 64'(r_nmem), 64'(e_hit ? 0 : 1));
      if (!w) chk_read($sformatf("rnd%0d", t), d, ref_mem[a[9:2]]);
      chk($sformatf("rnd%0d_counts", t), 64'({hit_count, miss_count}), 64'({4'(eh), 4'(em)}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
